// File: rtl/fgen_ctrl.sv
// fgen_ctrl: sequencing controller for funct_generator.
// Drives the generator's enable, config strobe, amplitude and waveform select,
// runs bursts of a programmed sample count, throttles on FIFO almost-full and
// reports progress and overflow.
// Optional feature macro: FGEN_CTRL_AUTO_RESTART_EN, which restarts a burst that
// ended by count straight into RUN with the captured settings.

package fifo_defines_pkg;
  localparam int INT_BITS = 16;
endpackage

module fgen_ctrl #(
  parameter int INT_BITS    = fifo_defines_pkg::INT_BITS,
  parameter int CNT_W       = 16,
  parameter int CONF_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic signed [INT_BITS-1:0] cfg_amp_i,
  input  logic        [1:0]          cfg_sel_i,
  input  logic        [CNT_W-1:0]    burst_len_i,
  input  logic                       fifo_full_i,
  input  logic                       fifo_afull_i,
  input  logic                       gen_wr_i,
  output logic                       en_low_o,
  output logic                       enh_conf_o,
  output logic        [INT_BITS-1:0] amp_o,
  output logic        [1:0]          sel_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic        [CNT_W-1:0]    sample_cnt_o,
  output logic                       overflow_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONFI = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       CONF_LAST = 4'(CONF_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       conf_cnt_q;
  logic             stop_pend_q;
  logic [CNT_W-1:0] len_q;
  logic             len_nz;
  logic             burst_done;
  logic             counting;
  logic             accept_start;
  logic             restart;

  assign len_nz       = (len_q != '0);
  // The sample written this cycle is the last one of a finite burst.
  assign burst_done   = len_nz && gen_wr_i && (sample_cnt_o == len_q - CNT_W'(1));
  assign counting     = (state_q == S_RUN) || (state_q == S_HOLD) || (state_q == S_DONE);
  assign accept_start = (state_q == S_IDLE) && start_i;

`ifdef FGEN_CTRL_AUTO_RESTART_EN
  assign restart = (state_q == S_DONE) && (state_d == S_RUN);
`else
  assign restart = 1'b0;
`endif

  // Next-state decode; RUN/HOLD priority is stop, then burst end, then throttle.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CONFI;
      S_CONFI: if (conf_cnt_q == CONF_LAST)
                 state_d = (stop_pend_q || stop_i) ? S_DONE : S_RUN;
      S_RUN: begin
        if (stop_i || burst_done) state_d = S_DONE;
        else if (fifo_afull_i)    state_d = S_HOLD;
      end
      S_HOLD: begin
        if (stop_i || burst_done) state_d = S_DONE;
        else if (!fifo_afull_i)   state_d = S_RUN;
      end
`ifdef FGEN_CTRL_AUTO_RESTART_EN
      S_DONE:  state_d = (!stop_pend_q && len_nz) ? S_RUN : S_IDLE;
`else
      S_DONE:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register and config-strobe timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= S_IDLE;
      conf_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      conf_cnt_q <= (state_q == S_CONFI) ? conf_cnt_q + 4'd1 : 4'd0;
    end
  end

  // Captured configuration, stop-pending flag, sample counter and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amp_o        <= '0;
      sel_o        <= '0;
      len_q        <= '0;
      stop_pend_q  <= 1'b0;
      sample_cnt_o <= '0;
      overflow_o   <= 1'b0;
    end else if (accept_start) begin
      amp_o        <= cfg_amp_i;
      sel_o        <= cfg_sel_i;
      len_q        <= burst_len_i;
      stop_pend_q  <= 1'b0;
      sample_cnt_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      // A stop seen in CONFI is remembered until the strobe completes;
      // in RUN/HOLD it marks the burst as stop-terminated.
      if (stop_i && (state_q == S_CONFI || state_q == S_RUN || state_q == S_HOLD))
        stop_pend_q <= 1'b1;
      if (restart)
        sample_cnt_o <= '0;
      else if (gen_wr_i && counting && sample_cnt_o != CNT_MAX)
        sample_cnt_o <= sample_cnt_o + CNT_W'(1);
      if (gen_wr_i && fifo_full_i)
        overflow_o <= 1'b1;
    end
  end

  // Control outputs decoded from the state register only.
  assign en_low_o   = (state_q != S_RUN);
  assign enh_conf_o = (state_q == S_CONFI);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_fgen_ctrl.sv
// tb_fgen_ctrl: directed, table-driven bench for fgen_ctrl (default build).
// u_dut uses CONF_CYCLES=2, u_dut3 uses CONF_CYCLES=3; both use CNT_W=4.

module tb_fgen_ctrl;

  localparam int INT_BITS = 16;
  localparam int CNT_W    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0, stop = 1'b0;
  logic [INT_BITS-1:0] amp_in = '0;
  logic [1:0]          sel_in = '0;
  logic [CNT_W-1:0]    len_in = '0;
  logic                full = 1'b0, afull = 1'b0, gw = 1'b0;

  logic                en_low, conf, busy, done, ovf;
  logic [INT_BITS-1:0] amp;
  logic [1:0]          sel;
  logic [CNT_W-1:0]    cnt;

  logic                en_low3, conf3, busy3, done3, ovf3;
  logic [INT_BITS-1:0] amp3;
  logic [1:0]          sel3;
  logic [CNT_W-1:0]    cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fgen_ctrl #(.INT_BITS(INT_BITS), .CNT_W(CNT_W), .CONF_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
    .cfg_amp_i(amp_in), .cfg_sel_i(sel_in), .burst_len_i(len_in),
    .fifo_full_i(full), .fifo_afull_i(afull), .gen_wr_i(gw),
    .en_low_o(en_low), .enh_conf_o(conf), .amp_o(amp), .sel_o(sel),
    .busy_o(busy), .done_o(done), .sample_cnt_o(cnt), .overflow_o(ovf)
  );

  fgen_ctrl #(.INT_BITS(INT_BITS), .CNT_W(CNT_W), .CONF_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
    .cfg_amp_i(amp_in), .cfg_sel_i(sel_in), .burst_len_i(len_in),
    .fifo_full_i(full), .fifo_afull_i(afull), .gen_wr_i(gw),
    .en_low_o(en_low3), .enh_conf_o(conf3), .amp_o(amp3), .sel_o(sel3),
    .busy_o(busy3), .done_o(done3), .sample_cnt_o(cnt3), .overflow_o(ovf3)
  );

  typedef struct {
    logic                start, stop;
    logic [INT_BITS-1:0] amp;
    logic [1:0]          sel;
    logic [CNT_W-1:0]    len;
    logic                afull, full, gw;
    logic                e_en_low, e_conf, e_busy, e_done;
    logic [CNT_W-1:0]    e_cnt;
    logic                e_ovf;
    logic [INT_BITS-1:0] e_amp;
    logic [1:0]          e_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, sp, input logic [INT_BITS-1:0] a, input logic [1:0] s,
                     input logic [CNT_W-1:0] l, input logic af, fu, w,
                     input logic enl, cf, bz, dn, input logic [CNT_W-1:0] c, input logic ov,
                     input logic [INT_BITS-1:0] ea, input logic [1:0] es);
    vec_t v;
    v.start = st; v.stop = sp; v.amp = a; v.sel = s; v.len = l;
    v.afull = af; v.full = fu; v.gw = w;
    v.e_en_low = enl; v.e_conf = cf; v.e_busy = bz; v.e_done = dn;
    v.e_cnt = c; v.e_ovf = ov; v.e_amp = ea; v.e_sel = es;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; amp_in = '0; sel_in = '0; len_in = '0;
    full = 1'b0; afull = 1'b0; gw = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   st sp amp      sel len af fu gw | enl cf bz dn cnt ov amp      sel
    // Basic burst: amp=5 sel=2 len=4.
    add(1, 0, 16'd5,  2, 4,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd5,  2);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd5,  2);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0,  0, 16'd5,  2);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 1,  0, 16'd5,  2);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 2,  0, 16'd5,  2);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 3,  0, 16'd5,  2);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   1, 0, 1, 1, 4,  0, 16'd5,  2);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 4,  0, 16'd5,  2);
    // Throttle: len=10, afull for 3 cycles, an in-flight sample counted in HOLD.
    add(1, 0, 16'd7,  1, 10, 0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 1,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 2,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  1, 0, 1,   1, 0, 1, 0, 3,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  1, 0, 1,   1, 0, 1, 0, 4,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  1, 0, 0,   1, 0, 1, 0, 4,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 4,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 5,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 6,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 7,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 8,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 9,  0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   1, 0, 1, 1, 10, 0, 16'd7,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 10, 0, 16'd7,  1);
    // Overflow: write while full, sticky through DONE/IDLE, cleared by next start.
    add(1, 0, 16'hfff0, 3, 2, 0, 0, 0,  1, 1, 1, 0, 0,  0, 16'hfff0, 3);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'hfff0, 3);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0,  0, 16'hfff0, 3);
    add(0, 0, 16'd0,  0, 0,  0, 1, 1,   0, 0, 1, 0, 1,  1, 16'hfff0, 3);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   1, 0, 1, 1, 2,  1, 16'hfff0, 3);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 2,  1, 16'hfff0, 3);
    // Next start clears overflow; stop in CONFI waits for the strobe to finish.
    add(1, 0, 16'd1,  0, 2,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd1,  0);
    add(0, 1, 16'd0,  0, 0,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd1,  0);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 0, 1, 1, 0,  0, 16'd1,  0);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 0,  0, 16'd1,  0);
    // Start+stop together in IDLE: start wins. Burst length 1 ends on first write.
    add(1, 1, 16'd2,  1, 1,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd2,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd2,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0,  0, 16'd2,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   1, 0, 1, 1, 1,  0, 16'd2,  1);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 1,  0, 16'd2,  1);
    // Start ignored in CONFI; stop in RUN; stop ignored in DONE and IDLE.
    add(1, 0, 16'd3,  2, 0,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd3,  2);
    add(1, 0, 16'd9,  0, 5,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd3,  2);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0,  0, 16'd3,  2);
    add(0, 1, 16'd0,  0, 0,  0, 0, 0,   1, 0, 1, 1, 0,  0, 16'd3,  2);
    add(0, 1, 16'd0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 0,  0, 16'd3,  2);
    add(0, 1, 16'd0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 0,  0, 16'd3,  2);
    // Stop, burst completion and afull together: DONE, last write counted.
    add(1, 0, 16'd4,  3, 2,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd4,  3);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 1, 1, 0, 0,  0, 16'd4,  3);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   0, 0, 1, 0, 0,  0, 16'd4,  3);
    add(0, 0, 16'd0,  0, 0,  0, 0, 1,   0, 0, 1, 0, 1,  0, 16'd4,  3);
    add(0, 1, 16'd0,  0, 0,  1, 0, 1,   1, 0, 1, 1, 2,  0, 16'd4,  3);
    add(0, 0, 16'd0,  0, 0,  0, 0, 0,   1, 0, 0, 0, 2,  0, 16'd4,  3);

    // Reset state.
    #12;
    check("rst en_low", en_low, 1);
    check("rst conf",   conf,   0);
    check("rst busy",   busy,   0);
    check("rst done",   done,   0);
    check("rst cnt",    cnt,    0);
    check("rst ovf",    ovf,    0);
    check("rst amp",    amp,    0);
    check("rst sel",    sel,    0);
    @(negedge clk); rst = 1'b1;
    tick();

    // Table-driven vectors.
    foreach (vecs[i]) begin
      start = vecs[i].start; stop = vecs[i].stop; amp_in = vecs[i].amp;
      sel_in = vecs[i].sel; len_in = vecs[i].len; afull = vecs[i].afull;
      full = vecs[i].full; gw = vecs[i].gw;
      tick();
      check($sformatf("v%0d en_low", i), en_low, vecs[i].e_en_low);
      check($sformatf("v%0d conf", i),   conf,   vecs[i].e_conf);
      check($sformatf("v%0d busy", i),   busy,   vecs[i].e_busy);
      check($sformatf("v%0d done", i),   done,   vecs[i].e_done);
      check($sformatf("v%0d cnt", i),    cnt,    vecs[i].e_cnt);
      check($sformatf("v%0d ovf", i),    ovf,    vecs[i].e_ovf);
      check($sformatf("v%0d amp", i),    amp,    vecs[i].e_amp);
      check($sformatf("v%0d sel", i),    sel,    vecs[i].e_sel);
    end
    idle_inputs();

    // Stop during the first CONFI cycle with CONF_CYCLES=3.
    begin
      int conf_seen = 0;
      int done_seen = 0;
      int run_seen  = 0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      tick();
      start = 1'b1; len_in = 4'd5; amp_in = 16'd6;
      tick();
      start = 1'b0; len_in = '0; amp_in = '0;
      if (conf3) conf_seen++;
      stop = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick();
        stop = 1'b0;
        if (conf3)   conf_seen++;
        if (done3)   done_seen++;
        if (!en_low3) run_seen++;
      end
      check("cfgstop conf cycles", conf_seen, 3);
      check("cfgstop done pulses", done_seen, 1);
      check("cfgstop run cycles",  run_seen,  0);
      check("cfgstop busy",        busy3,     0);
      check("cfgstop cnt",         cnt3,      0);
    end

    // Continuous mode: 20 writes saturate the 4-bit counter at 15, then stop.
    begin
      start = 1'b1; len_in = 4'd0; amp_in = 16'd8; sel_in = 2'd1;
      tick();
      idle_inputs();
      for (int k = 0; k < 10 && en_low; k++) tick();
      check("cont reach run", en_low, 0);
      gw = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      gw = 1'b0;
      check("cont cnt sat",  cnt,    15);
      check("cont still run", en_low, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("cont stop done",   done,   1);
      check("cont stop en_low", en_low, 1);
      tick();
      check("cont idle busy", busy, 0);
      check("cont idle cnt",  cnt,  15);
    end

    // Asynchronous reset in the middle of a burst.
    begin
      start = 1'b1; len_in = 4'd8; amp_in = 16'd11; sel_in = 2'd3;
      tick();
      idle_inputs();
      for (int k = 0; k < 10 && en_low; k++) tick();
      check("arst reach run", en_low, 0);
      gw = 1'b1;
      repeat (3) tick();
      check("arst pre cnt", cnt, 3);
      #2 rst = 1'b0;
      #1;
      check("arst en_low", en_low, 1);
      check("arst busy",   busy,   0);
      check("arst cnt",    cnt,    0);
      check("arst amp",    amp,    0);
      check("arst conf",   conf,   0);
      gw = 1'b0;
      #2 rst = 1'b1;
      tick();
      check("arst after busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fgen_ctrl.md
# fgen_ctrl

Sequencing controller for `funct_generator`. It drives the generator's enable, config strobe, amplitude and waveform select, and runs bursts of a programmed sample count. It throttles generation from the downstream FIFO's full/almost-full flags and reports progress and overflow to the host. The block sits between the host/register side and `funct_generator`; the generator's `wr_en_o` is looped back as `gen_wr_i`.

## Interface
- `INT_BITS`, default `fifo_defines_pkg::INT_BITS`: amplitude width, matches the generator's `amp_i`.
- `CNT_W`, default 16: width of the burst length and the sample counter.
- `CONF_CYCLES`, default 2, range 1..15: number of cycles `enh_conf_o` is held high per configuration.

Ports:
- `clk`  in  1  — the single clock; all logic is on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `start_i`  in  1  — start pulse; honoured only in IDLE.
- `stop_i`  in  1  — stop pulse.
- `cfg_amp_i`  in  INT_BITS signed  — amplitude, captured on an accepted start.
- `cfg_sel_i`  in  2  — waveform select, captured on an accepted start.
- `burst_len_i`  in  CNT_W  — samples per burst, captured on an accepted start; 0 means continuous.
- `fifo_full_i`  in  1  — downstream FIFO full.
- `fifo_afull_i`  in  1  — downstream FIFO almost full.
- `gen_wr_i`  in  1  — the generator's `wr_en_o`; one sample per high cycle.
- `en_low_o`  out  1  — generator enable, active-low.
- `enh_conf_o`  out  1  — generator config strobe.
- `amp_o`  out  INT_BITS  — registered amplitude.
- `sel_o`  out  2  — registered waveform select.
- `busy_o`  out  1  — high when state ≠ IDLE.
- `done_o`  out  1  — one-cycle pulse in DONE.
- `sample_cnt_o`  out  CNT_W  — samples counted in the current burst.
- `overflow_o`  out  1  — sticky: a sample was written while `fifo_full_i` was high.

## Operation
- FSM states: IDLE, CONFI, RUN, HOLD, DONE. All outputs are registered or decoded from the state register only.
- `en_low_o` = 0 only in RUN.
- `enh_conf_o` = 1 only in CONFI.
- IDLE:
  - On `start_i`: capture `amp_o`, `sel_o` and the burst length; clear `sample_cnt_o` and `overflow_o`; go to CONFI.
- CONFI:
  - Stays for exactly CONF_CYCLES cycles, timed by a local counter.
  - Then goes to DONE if a stop is pending, otherwise to RUN.
- RUN, transitions in priority order:
  - `stop_i` → DONE.
  - Burst complete (burst length ≠ 0, `gen_wr_i` high and count == length−1) → DONE.
  - `fifo_afull_i` → HOLD.
- HOLD:
  - `stop_i` → DONE.
  - `!fifo_afull_i` → RUN.
  - `gen_wr_i` is still counted here (samples already in flight), and can also complete the burst → DONE.
- DONE: asserts `done_o` for one cycle, then IDLE.
- Counter rules:
  - `sample_cnt_o` increments on `gen_wr_i` in RUN, HOLD or DONE.
  - It saturates at 2^CNT_W−1.
  - It holds its value in IDLE until the next accepted start.
- `overflow_o` sets on `gen_wr_i & fifo_full_i` in any state; it clears only on an accepted start or on reset.

## Timing
- Reset values:
  - `en_low_o` = 1; all other outputs 0.
  - `amp_o`, `sel_o`, `sample_cnt_o` = 0.
  - State = IDLE; stop-pending flag cleared.
- Start latency: `start_i` sampled at edge N gives CONFI from N+1 to N+CONF_CYCLES, and RUN (`en_low_o` = 0) at N+CONF_CYCLES+1.
- Stop latency: `stop_i` at edge N in RUN or HOLD gives DONE (`en_low_o` = 1) at N+1 and IDLE at N+2.
- Stop during CONFI: latched as a pending stop; the config strobe always completes its full CONF_CYCLES.
- Start ignored outside IDLE; `stop_i` ignored in IDLE and DONE.
- Simultaneous `start_i` and `stop_i` in IDLE: start wins; the stop is dropped.
- Simultaneous `stop_i`, burst completion and `fifo_afull_i`: go to DONE; the count still includes that `gen_wr_i`.
- Throttle latency: `fifo_afull_i` at edge N gives `en_low_o` = 1 at N+1.
- Counter boundaries:
  - Burst length 1: DONE on the first `gen_wr_i`.
  - Burst length 0: runs until stop; the counter saturates and does not wrap.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronously); `en_low_o` = 1.

## Configuration
- `FGEN_CTRL_AUTO_RESTART_EN` defined:
  - A burst that ends by count (burst length ≠ 0, no stop pending) goes DONE → RUN.
  - `sample_cnt_o` is cleared and the captured amp/sel are reused, with no CONFI.
  - `done_o` still pulses once per burst.
  - A stop-terminated burst goes to IDLE.
- Not defined: DONE always goes to IDLE.

## Test plan
- Basic burst:
  - Stimulus: CONF_CYCLES=2; start with amp=5, sel=2, len=4; FIFO never full; `gen_wr_i` every RUN cycle.
  - Response: `enh_conf_o` high for 2 cycles, `amp_o`=5, `sel_o`=2, 4 samples counted, `done_o` pulse, `sample_cnt_o`=4, `en_low_o`=1 after.
- Throttle:
  - Stimulus: len=10; `fifo_afull_i` high for 3 cycles mid-burst.
  - Response: HOLD for 3 cycles with `en_low_o`=1, resume RUN, final count 10.
- Stop during CONFI:
  - Stimulus: CONF_CYCLES=3; `stop_i` in the 1st CONFI cycle.
  - Response: `enh_conf_o` high for 3 cycles, then DONE, IDLE; `en_low_o` never 0; count 0.
- Overflow:
  - Stimulus: `gen_wr_i` together with `fifo_full_i`.
  - Response: `overflow_o`=1 and it stays 1 after DONE; the next start clears it.
- Continuous mode:
  - Stimulus: len=0, CNT_W=4; 20 writes, then stop.
  - Response: count saturates at 15; DONE one cycle after stop.
- Reset during RUN:
  - Stimulus: `rst`=0 asynchronously mid-burst.
  - Response: `en_low_o`=1 and `busy_o`=0 immediately; count 0.
